// File: rtl/fir_pkg.sv
// Shared definitions for the FIR lowpass chain: default widths, sample type, clamp helper.
package fir_pkg;

    localparam int unsigned DEF_IN_W  = 16;
    localparam int unsigned DEF_OUT_W = 8;

    // Signed sample type exchanged between the FIR filter and its downstream stages.
    typedef logic signed [DEF_IN_W-1:0] sample_t;

    // Clamp a signed value to the range of a w-bit signed integer (w in 1..31).
    function automatic logic signed [31:0] sat_clamp(input logic signed [31:0] r,
                                                     input int unsigned w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 32'd1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 32'd1));
        if (r > hi) begin
            return hi;
        end
        if (r < lo) begin
            return lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_decim_requant_fifo.sv
// Synchronous show-ahead FIFO; a write while full is accepted only with a same-cycle read.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned LVL_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop_c;
    logic             push_c;
    logic [AW-1:0]    rd_ptr_nxt_c;
    logic [LVL_W-1:0] level_nxt_c;
    logic [LVL_W-1:0] level_after_pop_c;

    // Accepted read/write strobes and next-state occupancy.
    always_comb begin
        pop_c             = rd_en && !empty;
        push_c            = wr_en && (!full || pop_c);
        rd_ptr_nxt_c      = rd_ptr + AW'(pop_c);
        level_after_pop_c = level - LVL_W'(pop_c);
        level_nxt_c       = level_after_pop_c + LVL_W'(push_c);
    end

    // Storage array, written at the tail.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, level, status and registered head word (held while empty).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            full    <= 1'b0;
            empty   <= 1'b1;
            rd_data <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push_c);
            rd_ptr <= rd_ptr_nxt_c;
            level  <= level_nxt_c;
            full   <= (level_nxt_c == LVL_W'(DEPTH));
            empty  <= (level_nxt_c == '0);
            if (level_nxt_c != '0) begin
                // Word being written becomes the head if nothing else remains.
                rd_data <= (level_after_pop_c == '0) ? wr_data : mem[rd_ptr_nxt_c];
            end
        end
    end

endmodule

// File: rtl/fir_decim_requant.sv
// Decimate the FIR output, requantize with round-half-up and saturation, buffer in a FIFO.
module fir_decim_requant
    import fir_pkg::*;
#(
    parameter int unsigned IN_W  = DEF_IN_W,
    parameter int unsigned OUT_W = DEF_OUT_W,
    parameter int unsigned DECIM = 2,
    parameter int unsigned SHIFT = 3,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [IN_W-1:0]          in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     sat_flag,
    output logic                     ovf_flag,
    input  logic                     clr_flags
);

    localparam int unsigned CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int unsigned EXT_W = IN_W + 1;
    localparam logic signed [EXT_W-1:0] RND =
        (SHIFT > 0) ? (EXT_W'(1) << (SHIFT - 1)) : EXT_W'(0);

    logic [CNT_W-1:0]        cnt;
    logic                    keep_c;
    logic signed [EXT_W-1:0] sum_c;
    logic signed [EXT_W-1:0] shr_c;
    logic signed [31:0]      clamp_c;
    logic                    sat_c;
    logic                    q_valid;
    logic [OUT_W-1:0]        q_data;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    pop_c;
    logic                    ovf_c;

    // Keep decision, rounding shift, clamp detection and overflow detection.
    always_comb begin
        keep_c  = in_valid && (cnt == '0);
        sum_c   = $signed({in_data[IN_W-1], in_data}) + RND;
        shr_c   = sum_c >>> SHIFT;
        clamp_c = sat_clamp(32'(shr_c), OUT_W);
        sat_c   = (clamp_c != 32'(shr_c));
        pop_c   = out_ready && !fifo_empty;
        ovf_c   = q_valid && fifo_full && !pop_c;
    end

    // Decimation phase, advanced only by valid input samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (in_valid) begin
            cnt <= (cnt == CNT_W'(DECIM - 1)) ? '0 : cnt + CNT_W'(1);
        end
    end

    // Requantized sample register feeding the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_valid <= 1'b0;
            q_data  <= '0;
        end else begin
            q_valid <= keep_c;
            if (keep_c) begin
                q_data <= clamp_c[OUT_W-1:0];
            end
        end
    end

    // Sticky status flags; a set event overrides a coincident clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_flag <= 1'b0;
            ovf_flag <= 1'b0;
        end else begin
            sat_flag <= (keep_c && sat_c) || (sat_flag && !clr_flags);
            ovf_flag <= ovf_c || (ovf_flag && !clr_flags);
        end
    end

    sync_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (q_valid),
        .wr_data (q_data),
        .rd_en   (out_ready),
        .rd_data (out_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign out_valid = !fifo_empty;

endmodule

// File: tb/tb_fir_decim_requant.sv
// Bench for fir_decim_requant: two instances (DECIM=2 and DECIM=1) share stimulus
// and are checked every cycle against a queue-based model, plus directed sequences.
module tb_fir_decim_requant;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_ready;
    logic        clr_flags;

    logic        ov2, ov1, sat2, sat1, ovf2, ovf1;
    logic [7:0]  od2, od1;
    logic [3:0]  lv2, lv1;

    always #5 clk = ~clk;

    fir_decim_requant #(.IN_W(16), .OUT_W(8), .DECIM(2), .SHIFT(3), .DEPTH(DEPTH)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .fifo_level(lv2),
        .sat_flag(sat2), .ovf_flag(ovf2), .clr_flags(clr_flags));

    fir_decim_requant #(.IN_W(16), .OUT_W(8), .DECIM(1), .SHIFT(3), .DEPTH(DEPTH)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .fifo_level(lv1),
        .sat_flag(sat1), .ovf_flag(ovf1), .clr_flags(clr_flags));

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state, index 0 = DECIM 2, index 1 = DECIM 1.
    int m_nv[2];
    bit m_pv[2];
    int m_pd[2];
    int mq[2][$];
    bit m_sat[2];
    bit m_ovf[2];
    int m_last[2];

    typedef struct {
        int din;
        int dout;
        bit sat;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    // round(x / 8) half-up, then clamp to signed 8 bits
    function automatic int rq(input int x, output bit s);
        int r;
        r = (x + 4) >>> 3;
        s = 1'b0;
        if (r > 127) begin
            r = 127;
            s = 1'b1;
        end else if (r < -128) begin
            r = -128;
            s = 1'b1;
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_nv[d]   = 0;
            m_pv[d]   = 1'b0;
            m_pd[d]   = 0;
            mq[d].delete();
            m_sat[d]  = 1'b0;
            m_ovf[d]  = 1'b0;
            m_last[d] = 0;
        end
    endtask

    // One clock edge of the model, using the inputs present at that edge.
    task automatic model_update();
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int d = 0; d < 2; d++) begin
            int dec;
            bit pop;
            bit kept;
            bit s;
            bit sovf;
            int v;
            dec  = (d == 0) ? 2 : 1;
            pop  = (mq[d].size() > 0) && out_ready;
            sovf = 1'b0;
            if (pop) void'(mq[d].pop_front());
            if (m_pv[d]) begin
                if (mq[d].size() < DEPTH) mq[d].push_back(m_pd[d]);
                else sovf = 1'b1;
            end
            kept = in_valid && (m_nv[d] % dec == 0);
            if (in_valid) m_nv[d]++;
            v = rq(int'($signed(in_data)), s);
            m_pv[d] = kept;
            if (kept) m_pd[d] = v;
            m_sat[d] = (kept && s) || (m_sat[d] && !clr_flags);
            m_ovf[d] = sovf || (m_ovf[d] && !clr_flags);
            if (mq[d].size() > 0) m_last[d] = mq[d][0];
        end
    endtask

    task automatic cmp_all();
        chk("m_valid2", int'(ov2), int'(mq[0].size() > 0));
        chk("m_data2", int'($signed(od2)), m_last[0]);
        chk("m_level2", int'(lv2), mq[0].size());
        chk("m_sat2", int'(sat2), int'(m_sat[0]));
        chk("m_ovf2", int'(ovf2), int'(m_ovf[0]));
        chk("m_valid1", int'(ov1), int'(mq[1].size() > 0));
        chk("m_data1", int'($signed(od1)), m_last[1]);
        chk("m_level1", int'(lv1), mq[1].size());
        chk("m_sat1", int'(sat1), int'(m_sat[1]));
        chk("m_ovf1", int'(ovf1), int'(m_ovf[1]));
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        cmp_all();
    endtask

    task automatic drv(input bit v, input int x);
        in_valid = v;
        in_data  = 16'(x);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        clr_flags = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[14];
        int   exp3[4];
        int   exp6[8];
        int   mode;

        tbl[0]  = '{-12,   -1,   1'b0};
        tbl[1]  = '{-13,   -2,   1'b0};
        tbl[2]  = '{4,     1,    1'b0};
        tbl[3]  = '{3,     0,    1'b0};
        tbl[4]  = '{2000,  127,  1'b1};
        tbl[5]  = '{-2000, -128, 1'b1};
        tbl[6]  = '{1019,  127,  1'b0};
        tbl[7]  = '{1020,  127,  1'b1};
        tbl[8]  = '{-1024, -128, 1'b0};
        tbl[9]  = '{-1029, -128, 1'b1};
        tbl[10] = '{32767, 127,  1'b1};
        tbl[11] = '{-32768, -128, 1'b1};
        tbl[12] = '{-5,    -1,   1'b0};
        tbl[13] = '{0,     0,    1'b0};

        model_reset();

        // Reset state
        do_reset();
        chk("rst_valid", int'(ov2), 0);
        chk("rst_data", int'(od2), 0);
        chk("rst_level", int'(lv2), 0);

        // Reset mid-burst with 3 entries buffered and sat_flag set
        out_ready = 1'b0;
        drv(1, 2000); step();
        drv(1, 5);    step();
        drv(1, 80);   step();
        drv(1, 5);    step();
        drv(1, 160);  step();
        drv(1, 5);    step();
        drv(0, 0);    step(); step();
        chk("t1_level_pre", int'(lv2), 3);
        chk("t1_sat_pre", int'(sat2), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_valid_async", int'(ov2), 0);
        chk("t1_level_async", int'(lv2), 0);
        chk("t1_sat_async", int'(sat2), 0);
        chk("t1_ovf_async", int'(ovf2), 0);
        chk("t1_data_async", int'(od2), 0);
        model_reset();
        #1 rst_n = 1'b1;
        drv(1, 40); step();
        drv(1, 41); step();
        drv(0, 0);
        chk("t1_first_valid", int'(ov2), 1);
        chk("t1_first_data", int'($signed(od2)), 5);

        // Decimation by 2 with idle gaps, 2-cycle latency
        do_reset();
        out_ready = 1'b1;
        drv(1, 80);  step(); chk("t2_lat1", int'(ov2), 0);
        drv(0, 0);   step(); chk("t2_v10", int'(ov2), 1); chk("t2_d10", int'($signed(od2)), 10);
        step();      chk("t2_pop10", int'(ov2), 0);
        drv(1, 81);  step();
        drv(0, 0);   step(); step(); chk("t2_skip81", int'(ov2), 0);
        drv(1, 160); step(); chk("t2_lat2", int'(ov2), 0);
        drv(0, 0);   step(); chk("t2_v20", int'(ov2), 1); chk("t2_d20", int'($signed(od2)), 20);
        drv(1, 161); step();
        drv(0, 0);   step(); step();
        chk("t2_skip161", int'(ov2), 0);
        chk("t2_hold", int'($signed(od2)), 20);

        // Table: single-sample requantization on the DECIM=1 instance
        for (int i = 0; i < 14; i++) begin
            do_reset();
            out_ready = 1'b1;
            drv(1, tbl[i].din); step();
            drv(0, 0);          step();
            chk($sformatf("tbl%0d_valid", i), int'(ov1), 1);
            chk($sformatf("tbl%0d_data", i), int'($signed(od1)), tbl[i].dout);
            chk($sformatf("tbl%0d_sat", i), int'(sat1), int'(tbl[i].sat));
        end

        // Back-to-back negatives and small values
        do_reset();
        out_ready = 1'b1;
        exp3 = '{-1, -2, 1, 0};
        drv(1, -12); step(); chk("t3_lat", int'(ov1), 0);
        drv(1, -13); step(); chk("t3_d0", int'($signed(od1)), exp3[0]);
        drv(1, 4);   step(); chk("t3_d1", int'($signed(od1)), exp3[1]);
        drv(1, 3);   step(); chk("t3_d2", int'($signed(od1)), exp3[2]);
        drv(0, 0);   step(); chk("t3_d3", int'($signed(od1)), exp3[3]);
        step();      chk("t3_empty", int'(ov1), 0);
        chk("t3_sat", int'(sat1), 0);

        // Saturation then flag clear
        do_reset();
        out_ready = 1'b1;
        drv(1, 2000); step();
        drv(0, 0);    step();
        chk("t4_sat_set", int'(sat1), 1);
        clr_flags = 1'b1; step(); clr_flags = 1'b0;
        chk("t4_sat_clr", int'(sat1), 0);

        // Backpressure overflow then drain
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drv(1, 8 * (i + 1)); step();
        end
        drv(0, 0); step(); step();
        chk("t5_level", int'(lv2), 8);
        chk("t5_ovf", int'(ovf2), 1);
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("t5_valid%0d", k), int'(ov2), 1);
            chk($sformatf("t5_data%0d", k), int'($signed(od2)), 2 * k + 1);
            step();
        end
        chk("t5_empty", int'(ov2), 0);

        // Full with simultaneous pop, then overflow coinciding with clear
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drv(1, 8 * (i + 1)); step();
        end
        drv(0, 0); step(); step();
        chk("t6_level_full", int'(lv2), 8);
        chk("t6_ovf_pre", int'(ovf2), 0);
        drv(1, 800); step();
        drv(0, 0); out_ready = 1'b1; step(); out_ready = 1'b0;
        chk("t6_level_pushpop", int'(lv2), 8);
        chk("t6_ovf_pushpop", int'(ovf2), 0);
        drv(1, 8);  step();
        drv(1, 16); step();
        drv(0, 0); clr_flags = 1'b1; step(); clr_flags = 1'b0;
        chk("t6_ovf_set_wins", int'(ovf2), 1);
        chk("t6_level_drop", int'(lv2), 8);
        exp6 = '{3, 5, 7, 9, 11, 13, 15, 100};
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("t6_data%0d", k), int'($signed(od2)), exp6[k]);
            step();
        end
        chk("t6_empty", int'(ov2), 0);

        // Randomized traffic against the model
        do_reset();
        mode = 0;
        for (int c = 0; c < 1500; c++) begin
            if (c % 64 == 0) mode = int'($urandom_range(0, 2));
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                in_valid = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 1) == 0) in_data = 16'($urandom);
                else in_data = 16'($urandom_range(0, 2047)) - 16'd1024;
                case (mode)
                    0:       out_ready = ($urandom_range(0, 3) == 0);
                    1:       out_ready = ($urandom_range(0, 1) == 0);
                    default: out_ready = ($urandom_range(0, 7) != 0);
                endcase
                clr_flags = ($urandom_range(0, 39) == 0);
                step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fir_decim_requant.md
Name: fir_decim_requant

Overview:
Downstream stage of the 8-tap FIR lowpass. Consumes the filter's 16-bit signed sample stream (valid-qualified, no backpressure) and decimates by DECIM. Requantizes each kept sample to OUT_W bits with round-half-up and saturation. Buffers results in a small FIFO and presents them on a valid/ready interface to the next consumer (DAC packer or bus writer).

Parameters:
IN_W, 16, input sample width (signed two's complement).
OUT_W, 8, output sample width (signed).
DECIM, 2, decimation ratio; keep 1 of every DECIM valid inputs; legal range 1..16.
SHIFT, 3, arithmetic right shift applied before saturation; legal range 0..IN_W-1.
DEPTH, 8, FIFO depth in entries; power of two, ≥2.

Ports:
clk  in  1  clock, all state on rising edge.
rst_n  in  1  asynchronous, active-low reset.
in_valid  in  1  in_data qualifier; one sample per asserted cycle.
in_data  in  IN_W  signed input sample.
out_valid  out  1  FIFO non-empty.
out_ready  in  1  consumer accepts out_data this cycle.
out_data  out  OUT_W  signed requantized sample, FIFO head.
fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
sat_flag  out  1  sticky: a sample was clamped.
ovf_flag  out  1  sticky: a sample was dropped on full FIFO.
clr_flags  in  1  synchronous clear of both sticky flags.

Behaviour:
- Reset: clk is clk; rst_n is an asynchronous, active-low reset. While rst_n is low, all state clears: decimation counter, pipeline register, FIFO pointers, and flags. out_valid=0, out_data=0, fifo_level=0, sat_flag=0, ovf_flag=0. Reset mid-stream discards all buffered data.
- Decimation: counter cnt runs 0..DECIM-1 and advances only on in_valid, wrapping to 0. A sample is kept when in_valid && cnt==0. The first valid sample after reset is kept. in_valid-low cycles do not advance the phase. DECIM=1 keeps every sample.
- Requant, registered stage 1:
  - Compute in IN_W+1 bits: r = (in_data + 2^(SHIFT-1)) >>> SHIFT. For SHIFT=0, r = in_data.
  - Clamp r to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Register q_data and q_valid; q_valid is the kept strobe.
  - A clamp on a kept sample sets sat_flag on the same edge that loads q_data.
- FIFO, stage 2:
  - Write when q_valid.
  - If full and no pop in the same cycle: sample is dropped, ovf_flag set, FIFO contents unchanged.
  - If full and a pop occurs in the same cycle: the write is accepted and the level stays DEPTH.
  - Show-ahead read: out_data = head entry whenever out_valid. Pop on out_valid && out_ready.
  - out_ready while empty has no effect.
  - No bypass path: a write into an empty FIFO makes out_valid=1 on the following cycle.
  - out_data holds its last value when empty (0 after reset).
- Latency: kept in_valid at edge N produces out_valid=1 after edge N+2 when the FIFO was empty.
- fifo_level is updated each edge: +1 on write only, -1 on pop only, unchanged on both or neither.
- Flags: clr_flags clears both flags. If a set event coincides with clr_flags, set wins.
- Ordering: output order equals kept-input order; no reordering or duplication.

Decomposition:
- Package fir_pkg: IN_W/OUT_W defaults, the sat_clamp function (width-generic min/max limits), and the shared signed sample type used by the FIR filter and this block.
- One sub-module: sync_fifo (parameters WIDTH, DEPTH). Ports: wr_en, wr_data, rd_en, rd_data, full, empty, level. It implements the full-with-simultaneous-read rule.
- Decimation and requant logic stay in the top module.

Test Plan:
1. Reset check, assert rst_n low mid-burst with 3 entries buffered -> immediately out_valid=0, fifo_level=0, flags=0; after release, next kept sample is the first valid input.
2. Decimation and rounding (DECIM=2, SHIFT=3, out_ready=1), in_valid with 80,81,160,161 and idle gaps between samples -> outputs exactly 10, 20; each appears 2 cycles after its input.
3. Rounding of negatives and small values (DECIM=1): inputs -12, -13, 4, 3 -> outputs -1, -2, 1, 0; sat_flag stays 0.
4. Saturation (DECIM=1): inputs 2000, -2000, 1019 -> outputs 127, -128, 127; sat_flag=1 after the first; clr_flags pulse -> 0.
5. Backpressure overflow (DECIM=2, out_ready=0), 20 consecutive valid inputs 8,16,...,160 -> level reaches 8 and ovf_flag=1. With out_ready=1 the FIFO then drains 1,3,5,...,15, then out_valid=0.
6. Full with simultaneous pop: hold level=8 and assert out_ready in the same cycle as a q_valid write -> level stays 8, ovf_flag stays 0, the new sample appears last; clr_flags coinciding with an overflow -> ovf_flag=1.
